// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder family: FSM state encoding
// and the bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold values 0..width, so it needs clog2(width+1) bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder, shared by the serial adder blocks.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    // Sum and carry of three one-bit inputs.
    always_comb begin
        s = a ^ b ^ cin;
        c = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands, processes one bit per
// clock LSB first through a single full_adder, then presents sum/cout.
// Optional subtract path (a + ~b + 1, cout = no-borrow) is built only when
// the macro SERIAL_ADDER_SUB_EN is defined.
//
// Handshake: an input transfer happens on an edge where in_valid=1 and
// in_ready=1; an output transfer happens on an edge where out_valid=1 and
// out_ready=1. Inputs are ignored whenever in_ready=0, and sum/cout hold
// stable while out_valid=1 and out_ready=0.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             b_bit;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             running;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_r;
    // Subtraction feeds the inverted b bit; the +1 comes from the preset carry.
    assign b_bit = b_sr[0] ^ sub_r;
`else
    assign b_bit = b_sr[0];
`endif

    assign accept  = (state == IDLE) && in_valid;
    assign running = (state == RUN);
    assign sum     = res_sr;
    assign cout    = carry;

    full_adder u_fa (
        .a   (a_sr[0]),
        .b   (b_bit),
        .cin (carry),
        .s   (fa_s),
        .c   (fa_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting, carry and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r  <= 1'b0;
`endif
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            cnt    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r  <= sub;
            carry  <= sub;
`else
            carry  <= 1'b0;
`endif
        end else if (running) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {fa_s, res_sr[WIDTH-1:1]};
            carry  <= fa_c;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8). Builds with or without
// SERIAL_ADDER_SUB_EN; the subtract vectors run only when it is defined.
module tb_serial_adder;

    localparam int WIDTH = 8;

    // ---------------- clock / reset / signals ----------------
    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub_drv;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks = 0;
    int errors = 0;
    bit armed  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    // Result is plain arithmetic on the operands: {cout,sum} = a+b or a+~b+1.
    function automatic logic [WIDTH:0] model_result(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic s);
`ifdef SERIAL_ADDER_SUB_EN
        if (s) begin
            return {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        end
`endif
        return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(s & 1'b0);
    endfunction

    logic [WIDTH:0] exp_q[$];
    int busy    = 0;
    int n_edges = 0;

    // An operation is busy from the accepting edge; its result is due WIDTH
    // edges later and stays due until an edge with out_ready=1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    = 0;
            n_edges = 0;
            exp_q.delete();
        end else if (busy == 0) begin
            if (in_valid) begin
                busy    = 1;
                n_edges = 0;
                exp_q.push_back(model_result(a, b, sub_drv));
            end
        end else if (n_edges == WIDTH) begin
            if (out_ready) begin
                busy = 0;
                void'(exp_q.pop_front());
            end
        end else begin
            n_edges++;
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (armed && !rst) begin
            check("cyc_in_ready", in_ready, busy == 0);
            check("cyc_out_valid", out_valid, (busy != 0) && (n_edges == WIDTH));
            if ((busy != 0) && (n_edges == WIDTH) && (exp_q.size() > 0)) begin
                check("cyc_sum", sum, exp_q[0][WIDTH-1:0]);
                check("cyc_cout", cout, exp_q[0][WIDTH]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at a falling edge with the block idle.
    task automatic do_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                         input logic op_sub, input int hold,
                         input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_accept", in_ready, 1);
        a        = op_a;
        b        = op_b;
        sub_drv  = op_sub;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        waited   = 0;
        while (!out_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("latency", waited, WIDTH);
        check("lit_sum", sum, exp_sum);
        check("lit_cout", cout, exp_cout);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = WIDTH'($urandom_range(0, 255));
            b        = WIDTH'($urandom_range(0, 255));
            sub_drv  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_sum", sum, exp_sum);
            check("hold_cout", cout, exp_cout);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("retire_in_ready", in_ready, 1);
        check("retire_out_valid", out_valid, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub_drv   = 1'b0;

        // Mid-cycle reset pulse, no clock edge before the checks.
        #12 rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        armed = 1'b1;

        // First accept lands on the first rising edge after reset release.
        do_op(8'h5A, 8'hA5, 1'b0, 0, 8'hFF, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1);
        do_op(8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0);
        do_op(8'h12, 8'h34, 1'b0, 5, 8'h46, 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1);
        do_op(8'h7F, 8'h01, 1'b0, 2, 8'h80, 1'b0);

        // Reset in the middle of RUN aborts the operation.
        a        = 8'h0F;
        b        = 8'h01;
        sub_drv  = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_abort_busy", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (WIDTH + 2) begin
            @(negedge clk);
            check("post_abort_out_valid", out_valid, 0);
            check("post_abort_in_ready", in_ready, 1);
        end
        do_op(8'h03, 8'h04, 1'b0, 0, 8'h07, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h10, 8'h01, 1'b1, 0, 8'h0F, 1'b1);
        do_op(8'h00, 8'h01, 1'b1, 0, 8'hFF, 1'b0);
        do_op(8'h05, 8'h05, 1'b1, 1, 8'h00, 1'b1);
        do_op(8'h00, 8'h01, 1'b0, 0, 8'h01, 1'b0);
`else
        // This build instantiates serial_adder with no sub connection: the
        // port must not exist for that to elaborate with every port bound.
        $display("note: add-only build, sub port not present on serial_adder");
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
